// File: rtl/mux8_rr_arbiter_if.sv
// Request/data/grant bundle between the eight requesters and the shared 8:1 bit mux arbiter.
// The master side raises req and drives I. The slave side is the arbiter, which returns gnt, s, busy and y.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] I;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       busy;
  logic       y;

  modport master (
    output req,
    output I,
    input  gnt,
    input  s,
    input  busy,
    input  y
  );

  modport slave (
    input  req,
    input  I,
    output gnt,
    output s,
    output busy,
    output y
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that shares one 8:1 bit mux among eight requesters.
// A grant is bounded to MAX_HOLD cycles, and a release hands over to the next requester on the same edge.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no grant active; gnt=0, busy=0, s keeps the last grantee
//   GRANT | requester s owns the mux; hold_q counts cycles of this grant
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux8_rr_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  s_q, s_d;
  logic [3:0]  hold_q, hold_d;
  logic [7:0]  gnt_q, gnt_d;
  logic        busy_q, busy_d;

  logic        any_req;
  logic        release_grant;
  logic [2:0]  next_base;
  logic [2:0]  pick_idx;

  // First set bit of v scanning upward from p with wrap. Scanning from the far end
  // lets the nearest hit overwrite the others.
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] p);
    logic [2:0] res;
    logic [2:0] idx;
    res = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (v[idx]) res = idx;
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      s_q     <= 3'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    any_req       = |bus.req;
    release_grant = !bus.req[s_q] || (hold_q == HOLD_LAST);
    // On a release the scan starts just past the outgoing grantee, so a sole requester wraps back to itself.
    next_base     = (state_q == GRANT) ? s_q + 3'd1 : ptr_q;
    pick_idx      = pick(bus.req, next_base);
    state_d       = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (release_grant && !any_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    s_d    = s_q;
    hold_d = hold_q;
    gnt_d  = gnt_q;
    busy_d = busy_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          s_d    = pick_idx;
          gnt_d  = 8'b1 << pick_idx;
          busy_d = 1'b1;
          hold_d = 4'd0;
        end
      end
      GRANT: begin
        if (!release_grant) begin
          hold_d = hold_q + 4'd1;
        end else begin
          ptr_d = s_q + 3'd1;
          if (any_req) begin
            s_d    = pick_idx;
            gnt_d  = 8'b1 << pick_idx;
            busy_d = 1'b1;
            hold_d = 4'd0;
          end else begin
            gnt_d  = 8'd0;
            busy_d = 1'b0;
            hold_d = 4'd0;
          end
        end
      end
      default: begin
        gnt_d  = 8'd0;
        busy_d = 1'b0;
        hold_d = 4'd0;
      end
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.s    = s_q;
  assign bus.busy = busy_q;
  assign bus.y    = busy_q ? bus.I[s_q] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: reset, sole-requester timeout, full rotation, drop-release,
// mid-grant reset and pointer wrap, plus continuous grant invariants.
module tb_mux8_rr_arbiter;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic chk_en;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Invariants: gnt is one-hot or zero, and gnt[s] matches busy.
  always @(negedge clk) begin
    if (chk_en) begin
      tests_run++;
      if ((bus.gnt & (bus.gnt - 8'd1)) !== 8'd0 || bus.gnt[bus.s] !== bus.busy) begin
        tests_failed++;
        $display("FAIL invariant: gnt=%b s=%0d busy=%b", bus.gnt, bus.s, bus.busy);
      end
    end
  end

  task automatic test_reset();
    bus.req = 8'd0;
    bus.I   = 8'hFF;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if ({bus.gnt, bus.s, bus.busy, bus.y} !== {8'd0, 3'd0, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset_idle c=%0d: gnt=%b s=%0d busy=%b y=%b, want all zero",
                 c, bus.gnt, bus.s, bus.busy, bus.y);
      end
    end
  endtask

  task automatic test_sole_timeout();
    bus.req = 8'd0;
    bus.I   = 8'b11001100;
    do_reset();
    bus.req = 8'b00000100;
    tick();
    tests_run++;
    if ({bus.gnt, bus.s, bus.busy, bus.y} !== {8'b00000100, 3'd2, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL sole_first: gnt=%b s=%0d busy=%b y=%b, want 00000100 2 1 1",
               bus.gnt, bus.s, bus.busy, bus.y);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run++;
      if ({bus.gnt, bus.s, bus.y} !== {8'b00000100, 3'd2, 1'b1}) begin
        tests_failed++;
        $display("FAIL sole_hold k=%0d: gnt=%b s=%0d y=%b, want 00000100 2 1", k, bus.gnt, bus.s, bus.y);
      end
      if (k == 3) begin
        tests_run++;
        if (dut.ptr_q !== 3'd0 || dut.hold_q !== 4'd3) begin
          tests_failed++;
          $display("FAIL sole_pre_timeout: ptr=%0d hold=%0d, want 0 3", dut.ptr_q, dut.hold_q);
        end
      end
      if (k == 4) begin
        tests_run++;
        if (dut.ptr_q !== 3'd3 || dut.hold_q !== 4'd0) begin
          tests_failed++;
          $display("FAIL sole_timeout_ptr: ptr=%0d hold=%0d, want 3 0", dut.ptr_q, dut.hold_q);
        end
      end
    end
  endtask

  task automatic test_all_rotate();
    logic [7:0] i_val;
    logic [2:0] es;
    i_val   = 8'b11001100;
    bus.I   = i_val;
    bus.req = 8'hFF;
    do_reset();
    for (int c = 1; c <= 36; c++) begin
      tick();
      es = 3'(((c - 1) / 4) % 8);
      tests_run++;
      if ({bus.gnt, bus.s, bus.busy, bus.y} !== {8'b1 << es, es, 1'b1, i_val[es]}) begin
        tests_failed++;
        $display("FAIL rotate c=%0d: gnt=%b s=%0d busy=%b y=%b, want s=%0d y=%b",
                 c, bus.gnt, bus.s, bus.busy, bus.y, es, i_val[es]);
      end
    end
  endtask

  task automatic test_drop_release();
    bus.req = 8'd0;
    bus.I   = 8'b00110011;
    do_reset();
    bus.req = 8'b00010001;
    tick();
    tests_run++;
    if ({bus.gnt, bus.s} !== {8'b00000001, 3'd0}) begin
      tests_failed++;
      $display("FAIL drop_first: gnt=%b s=%0d, want 00000001 0", bus.gnt, bus.s);
    end
    tick();
    bus.req = 8'b00010000;
    tick();
    tests_run++;
    if ({bus.gnt, bus.s, bus.busy, bus.y, dut.hold_q} !== {8'b00010000, 3'd4, 1'b1, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("FAIL drop_handover: gnt=%b s=%0d busy=%b y=%b hold=%0d, want 00010000 4 1 1 0",
               bus.gnt, bus.s, bus.busy, bus.y, dut.hold_q);
    end
    tick();
    tests_run++;
    if ({bus.gnt, dut.hold_q} !== {8'b00010000, 4'd1}) begin
      tests_failed++;
      $display("FAIL drop_hold: gnt=%b hold=%0d, want 00010000 1", bus.gnt, dut.hold_q);
    end
    bus.req = 8'd0;
    tick();
    tests_run++;
    if ({bus.gnt, bus.s, bus.busy, bus.y} !== {8'd0, 3'd4, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL drop_idle: gnt=%b s=%0d busy=%b y=%b, want 0 4 0 0", bus.gnt, bus.s, bus.busy, bus.y);
    end
    tick();
    tests_run++;
    if ({bus.gnt, bus.s, bus.busy} !== {8'd0, 3'd4, 1'b0}) begin
      tests_failed++;
      $display("FAIL drop_idle_hold: gnt=%b s=%0d busy=%b, want 0 4 0", bus.gnt, bus.s, bus.busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    bus.req = 8'd0;
    bus.I   = 8'hFF;
    do_reset();
    bus.req = 8'b00100000;
    for (int k = 0; k < 5; k++) tick();
    tests_run++;
    if ({bus.s, bus.busy, dut.ptr_q} !== {3'd5, 1'b1, 3'd6}) begin
      tests_failed++;
      $display("FAIL mid_setup: s=%0d busy=%b ptr=%0d, want 5 1 6", bus.s, bus.busy, dut.ptr_q);
    end
    bus.req = 8'b10100000;
    rst = 1'b1;
    tick();
    tests_run++;
    if ({bus.gnt, bus.s, bus.busy, bus.y, dut.ptr_q} !== {8'd0, 3'd0, 1'b0, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset: gnt=%b s=%0d busy=%b y=%b ptr=%0d, want 0 0 0 0 0",
               bus.gnt, bus.s, bus.busy, bus.y, dut.ptr_q);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({bus.gnt, bus.s, bus.busy} !== {8'b00100000, 3'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_after: gnt=%b s=%0d busy=%b, want 00100000 5 1", bus.gnt, bus.s, bus.busy);
    end
  endtask

  task automatic test_ptr_wrap();
    logic [2:0] es;
    bus.req = 8'd0;
    bus.I   = 8'b10000000;
    do_reset();
    bus.req = 8'b10000000;
    tick();
    bus.req = 8'b10000001;
    for (int c = 1; c <= 16; c++) begin
      es = ((((c - 1) / 4) % 2) == 0) ? 3'd7 : 3'd0;
      tests_run++;
      if ({bus.gnt, bus.s, bus.y} !== {8'b1 << es, es, (es == 3'd7)}) begin
        tests_failed++;
        $display("FAIL wrap c=%0d: gnt=%b s=%0d y=%b, want s=%0d", c, bus.gnt, bus.s, bus.y, es);
      end
      tick();
      if (c == 4) begin
        tests_run++;
        if (dut.ptr_q !== 3'd0) begin
          tests_failed++;
          $display("FAIL wrap_ptr: ptr=%0d, want 0", dut.ptr_q);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    chk_en       = 1'b0;
    rst          = 1'b1;
    bus.req      = 8'd0;
    bus.I        = 8'd0;
    test_reset();
    test_sole_timeout();
    test_all_rotate();
    test_drop_release();
    test_reset_mid_grant();
    test_ptr_wrap();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
